// File: rtl/alu_issue_ctrl.sv
// Requester-side ALU issue controller: accepts one op over valid/ready, drives the ALU,
// waits for completion (with timeout), and returns the captured result over valid/ready.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned MAX_SEL = 19,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SEL_W-1:0] req_sel,
    input  logic [TAG_W-1:0] req_tag,

    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [SEL_W-1:0] alu_Sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_complete,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,

    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    localparam logic [SEL_W-1:0] MaxSel  = SEL_W'(MAX_SEL);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]      op_count_q, op_count_d;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        tag_d      = tag_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        wait_cnt_d = wait_cnt_q;
        op_count_d = op_count_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    tag_d = req_tag;
                    if (req_sel <= MaxSel) begin
                        alu_a_d   = req_a;
                        alu_b_d   = req_b;
                        alu_sel_d = req_sel;
                        state_d   = StIssue;
                    end else begin
                        // Illegal select never reaches the ALU; answer with an error directly.
                        rsp_data_d = '0;
                        rsp_zero_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = StResp;
                    end
                end
            end
            StIssue: begin
                // alu_complete is deliberately ignored here to skip a stale strobe.
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (alu_complete) begin
                    rsp_data_d = alu_out;
                    rsp_zero_d = alu_zero;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (wait_cnt_q == CntLast) begin
                    rsp_data_d = '0;
                    rsp_zero_d = 1'b0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    if (!rsp_err_q) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            wait_cnt_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            tag_q      <= tag_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
            wait_cnt_q <= wait_cnt_d;
            op_count_q <= op_count_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign alu_A     = alu_a_q;
    assign alu_B     = alu_b_q;
    assign alu_Sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tag   = tag_q;
    assign op_count  = op_count_q;

endmodule
